// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks an in-place radix-2 DIT FFT over an external RAM.
// Build option: define FFT_SCALE_EN to halve every butterfly result half.
module fft_stage_sequencer #(
    parameter int N_LOG2   = 3,
    parameter int WORD_SZ  = 32,
    parameter int WORD_MID = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic [N_LOG2-1:0]  o_rd_addr_a,
    output logic [N_LOG2-1:0]  o_rd_addr_b,
    input  logic [WORD_SZ-1:0] i_rd_data_a,
    input  logic [WORD_SZ-1:0] i_rd_data_b,
    output logic [N_LOG2-1:0]  o_tw_addr_a,
    output logic [N_LOG2-1:0]  o_tw_addr_b,
    input  logic [WORD_SZ-1:0] i_tw_data_a,
    input  logic [WORD_SZ-1:0] i_tw_data_b,
    output logic [WORD_SZ-1:0] o_bf_A,
    output logic [WORD_SZ-1:0] o_bf_B,
    output logic [WORD_SZ-1:0] o_bf_twA,
    output logic [WORD_SZ-1:0] o_bf_twB,
    input  logic [WORD_SZ-1:0] i_bf_A,
    input  logic [WORD_SZ-1:0] i_bf_B,
    output logic               o_wr_en,
    output logic [N_LOG2-1:0]  o_wr_addr_a,
    output logic [N_LOG2-1:0]  o_wr_addr_b,
    output logic [WORD_SZ-1:0] o_wr_data_a,
    output logic [WORD_SZ-1:0] o_wr_data_b
);

    localparam int SW = $clog2(N_LOG2 + 1);
    localparam int HI_W = WORD_SZ - WORD_MID;
    localparam logic [N_LOG2-1:0] HALF_N = N_LOG2'(1 << (N_LOG2 - 1));
    localparam logic [N_LOG2-1:0] J_LAST = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
    localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);

`ifdef FFT_SCALE_EN
    localparam int RES_SHIFT = 1;
`else
    localparam int RES_SHIFT = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_EX,
        ST_WR,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SW-1:0]     s_q, s_d;
    logic [N_LOG2-1:0] j_q, j_d;
    logic              load;

    logic [N_LOG2-1:0] half, mask, pos;
    logic [N_LOG2-1:0] a_nxt, b_nxt, k_nxt, kb_nxt;
    logic [SW-1:0]     k_sh;

    logic [N_LOG2-1:0] addr_a_q, addr_b_q;
    logic [N_LOG2-1:0] tw_a_q, tw_b_q;

    logic [WORD_SZ-1:0] res_a, res_b;
    logic [WORD_SZ-1:0] wr_a_q, wr_b_q;
    logic               in_ex;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RD;
                    s_d     = '0;
                    j_d     = '0;
                    load    = 1'b1;
                end
            end
            ST_RD: state_d = ST_EX;
            ST_EX: state_d = ST_WR;
            ST_WR: begin
                if (j_q != J_LAST) begin
                    state_d = ST_RD;
                    j_d     = j_q + 1'b1;
                    load    = 1'b1;
                end else if (s_q != S_LAST) begin
                    state_d = ST_RD;
                    j_d     = '0;
                    s_d     = s_q + 1'b1;
                    load    = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = '0;
                j_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Addresses for the butterfly about to be read, computed from next (s,j).
    always_comb begin
        half   = N_LOG2'(1) << s_d;
        mask   = half - 1'b1;
        pos    = j_d & mask;
        a_nxt  = ((j_d & ~mask) << 1) | pos;
        b_nxt  = a_nxt + half;
        k_sh   = S_LAST - s_d;
        k_nxt  = pos << k_sh;
        kb_nxt = k_nxt + HALF_N;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_a_q   <= '0;
            tw_b_q   <= '0;
        end else if (load) begin
            addr_a_q <= a_nxt;
            addr_b_q <= b_nxt;
            tw_a_q   <= k_nxt;
            tw_b_q   <= kb_nxt;
        end
    end

    function automatic logic [WORD_SZ-1:0] shape(input logic [WORD_SZ-1:0] x);
        logic signed [HI_W-1:0]     hi;
        logic signed [WORD_MID-1:0] lo;
        hi = x[WORD_SZ-1:WORD_MID];
        lo = x[WORD_MID-1:0];
        hi = hi >>> RES_SHIFT;
        lo = lo >>> RES_SHIFT;
        return {hi, lo};
    endfunction

    assign res_a = shape(i_bf_A);
    assign res_b = shape(i_bf_B);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_a_q <= '0;
            wr_b_q <= '0;
        end else if (state_q == ST_EX) begin
            wr_a_q <= res_a;
            wr_b_q <= res_b;
        end
    end

    assign in_ex = (state_q == ST_EX);

    assign o_busy  = state_q inside {ST_RD, ST_EX, ST_WR};
    assign o_done  = (state_q == ST_DONE);
    assign o_wr_en = (state_q == ST_WR);

    assign o_rd_addr_a = addr_a_q;
    assign o_rd_addr_b = addr_b_q;
    assign o_wr_addr_a = addr_a_q;
    assign o_wr_addr_b = addr_b_q;
    assign o_tw_addr_a = tw_a_q;
    assign o_tw_addr_b = tw_b_q;

    assign o_bf_A   = in_ex ? i_rd_data_a : '0;
    assign o_bf_B   = in_ex ? i_rd_data_b : '0;
    assign o_bf_twA = in_ex ? i_tw_data_a : '0;
    assign o_bf_twB = in_ex ? i_tw_data_b : '0;

    assign o_wr_data_a = wr_a_q;
    assign o_wr_data_b = wr_b_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: 8-point bench with RAM, twiddle ROM and butterfly models.
// Write and done events are checked by a monitor against a queued scoreboard.
module tb_fft_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic        o_busy, o_done, o_wr_en;
    logic [2:0]  o_rd_addr_a, o_rd_addr_b, o_tw_addr_a, o_tw_addr_b;
    logic [2:0]  o_wr_addr_a, o_wr_addr_b;
    logic [31:0] rd_a_q, rd_b_q, tw_a_q, tw_b_q;
    logic [31:0] o_bf_A, o_bf_B, o_bf_twA, o_bf_twB;
    logic [31:0] i_bf_A, i_bf_B;
    logic [31:0] o_wr_data_a, o_wr_data_b;

    logic [31:0] ram [8];
    logic [31:0] img [8];
    logic        ld = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] k;
        logic [2:0] kb;
    } ent_t;

    ent_t q_addr[$];
    int   q_done[$];

    int a_t[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int b_t[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int k_t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fft_stage_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_addr_a (o_rd_addr_a),
        .o_rd_addr_b (o_rd_addr_b),
        .i_rd_data_a (rd_a_q),
        .i_rd_data_b (rd_b_q),
        .o_tw_addr_a (o_tw_addr_a),
        .o_tw_addr_b (o_tw_addr_b),
        .i_tw_data_a (tw_a_q),
        .i_tw_data_b (tw_b_q),
        .o_bf_A      (o_bf_A),
        .o_bf_B      (o_bf_B),
        .o_bf_twA    (o_bf_twA),
        .o_bf_twB    (o_bf_twB),
        .i_bf_A      (i_bf_A),
        .i_bf_B      (i_bf_B),
        .o_wr_en     (o_wr_en),
        .o_wr_addr_a (o_wr_addr_a),
        .o_wr_addr_b (o_wr_addr_b),
        .o_wr_data_a (o_wr_data_a),
        .o_wr_data_b (o_wr_data_b)
    );

    always #5 clk = ~clk;

    // W^k = exp(-j*2*pi*k/8) scaled by 64, {re, im}
    function automatic logic [31:0] rom(input logic [2:0] k);
        case (k)
            3'd0: return 32'h0040_0000;
            3'd1: return 32'h002D_FFD3;
            3'd2: return 32'h0000_FFC0;
            3'd3: return 32'hFFD3_FFD3;
            3'd4: return 32'hFFC0_0000;
            3'd5: return 32'hFFD3_002D;
            3'd6: return 32'h0000_0040;
            default: return 32'h002D_002D;
        endcase
    endfunction

    function automatic logic [31:0] bf(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] w);
        logic signed [15:0] ar, ai, br, bi, wr, wi;
        logic signed [31:0] pr, pi;
        logic [15:0]        rr, ri;
        ar = a[31:16];
        ai = a[15:0];
        br = b[31:16];
        bi = b[15:0];
        wr = w[31:16];
        wi = w[15:0];
        pr = (32'(br) * 32'(wr) - 32'(bi) * 32'(wi)) >>> 6;
        pi = (32'(br) * 32'(wi) + 32'(bi) * 32'(wr)) >>> 6;
        rr = ar + pr[15:0];
        ri = ai + pi[15:0];
        return {rr, ri};
    endfunction

    function automatic logic [31:0] scale(input logic [31:0] x);
        logic signed [15:0] r, i;
        r = x[31:16];
        i = x[15:0];
`ifdef FFT_SCALE_EN
        r = r >>> 1;
        i = i >>> 1;
`endif
        return {r, i};
    endfunction

    assign i_bf_A = bf(o_bf_A, o_bf_B, o_bf_twA);
    assign i_bf_B = bf(o_bf_A, o_bf_B, o_bf_twB);

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_a_q <= ram[o_rd_addr_a];
        rd_b_q <= ram[o_rd_addr_b];
        tw_a_q <= rom(o_tw_addr_a);
        tw_b_q <= rom(o_tw_addr_b);
        if (ld) begin
            ram <= img;
        end else if (o_wr_en) begin
            ram[o_wr_addr_a] <= o_wr_data_a;
            ram[o_wr_addr_b] <= o_wr_data_b;
        end
    end

    // Monitor: pops the scoreboard on every write strobe and done pulse
    always @(negedge clk) begin
        ent_t        e;
        logic [17:0] ga, xa;
        logic [63:0] gd, xd;
        int          xc;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (o_busy) busy_cnt++;
            if (o_wr_en) begin
                checks++;
                if (q_addr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected cyc=%0d a=%0d b=%0d",
                             cyc, o_wr_addr_a, o_wr_addr_b);
                end else begin
                    e  = q_addr.pop_front();
                    ga = {o_wr_addr_a, o_wr_addr_b, o_tw_addr_a, o_tw_addr_b,
                          o_rd_addr_a, o_rd_addr_b};
                    xa = {e.a, e.b, e.k, e.kb, e.a, e.b};
                    if (ga !== xa) begin
                        errors++;
                        $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, ga, xa);
                    end
                    checks++;
                    gd = {o_wr_data_a, o_wr_data_b};
                    xd = {scale(bf(ram[e.a], ram[e.b], rom(e.k))),
                          scale(bf(ram[e.a], ram[e.b], rom(e.kb)))};
                    if (gd !== xd) begin
                        errors++;
                        $display("FAIL wr_data cyc=%0d got=%h exp=%h", cyc, gd, xd);
                    end
                end
            end
            if (o_done) begin
                checks++;
                if (q_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d", cyc);
                end else begin
                    xc = q_done.pop_front();
                    if (cyc != xc || busy_cnt != 36 || o_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL done_timing cyc=%0d exp=%0d busy_cycles=%0d exp=36",
                                 cyc, xc, busy_cnt);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic load(input logic [31:0] w0, input logic [31:0] rest);
        img[0] = w0;
        for (int i = 1; i < 8; i++) img[i] = rest;
        @(negedge clk);
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic do_start();
        ent_t e;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            e.a  = 3'(a_t[i]);
            e.b  = 3'(b_t[i]);
            e.k  = 3'(k_t[i]);
            e.kb = 3'(k_t[i] + 4);
            q_addr.push_back(e);
        end
        q_done.push_back(cyc + 37);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (o_done) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout got=0 exp=1");
        end
    endtask

    task automatic check_ram(input logic [31:0] w0, input logic [31:0] rest);
        logic [31:0] x;
        for (int i = 0; i < 8; i++) begin
            x = (i == 0) ? w0 : rest;
            checks++;
            if (ram[i] !== x) begin
                errors++;
                $display("FAIL ram[%0d] got=%h exp=%h", i, ram[i], x);
            end
        end
    endtask

    initial begin
        logic [31:0] imp_x, dc0_x;
        bit          hit;
`ifdef FFT_SCALE_EN
        imp_x = 32'h0000_0000;
        dc0_x = 32'h0008_0000;
`else
        imp_x = 32'h0001_0000;
        dc0_x = 32'h0040_0000;
`endif
        rst_n   = 1'b0;
        i_start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_wr_en} !== 3'b000) begin
            errors++;
            $display("FAIL rst_ctrl got=%b exp=000", {o_busy, o_done, o_wr_en});
        end
        checks++;
        if ({o_rd_addr_a, o_rd_addr_b, o_tw_addr_a, o_tw_addr_b,
             o_wr_addr_a, o_wr_addr_b} !== 18'd0) begin
            errors++;
            $display("FAIL rst_addr got=%h exp=0", {o_rd_addr_a, o_rd_addr_b,
                     o_tw_addr_a, o_tw_addr_b, o_wr_addr_a, o_wr_addr_b});
        end
        checks++;
        if ({o_bf_A, o_bf_B, o_bf_twA, o_bf_twB, o_wr_data_a, o_wr_data_b} !== 192'd0) begin
            errors++;
            $display("FAIL rst_data got=nonzero exp=0");
        end
        i_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        load(32'h0001_0000, 32'h0);
        do_start();
        wait_done();
        check_ram(imp_x, imp_x);

        load(32'h0008_0000, 32'h0008_0000);
        do_start();
        repeat (9) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        check_ram(dc0_x, 32'h0);

        load(32'h0008_0000, 32'h0008_0000);
        do_start();
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (o_wr_en && o_wr_addr_a == 3'd0 && o_wr_addr_b == 3'd2) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL stage1_wr_seen got=0 exp=1");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_wr_en, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort got=%b exp=00", {o_wr_en, o_busy});
        end
        q_addr.delete();
        q_done.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        load(32'h0008_0000, 32'h0008_0000);
        do_start();
        wait_done();
        repeat (3) @(negedge clk);
        check_ram(dc0_x, 32'h0);

        checks++;
        if (q_addr.size() != 0 || q_done.size() != 0) begin
            errors++;
            $display("FAIL leftover got=%0d/%0d exp=0/0", q_addr.size(), q_done.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
